// File: rtl/ml_ahb_resp_mux_master_0_pkg.sv
// ---------------------------------------------------------------------------
// ml_ahb_resp_mux_master_0_pkg
// Shared AHB encodings for the master 0 data-phase response stage:
//   - htrans_e    : AHB transfer types
//   - hresp_e     : AHB response codes
//   - def_state_e : default-slave FSM state encoding
//   - is_active() : true for transfers that demand a real response
// ---------------------------------------------------------------------------
package ml_ahb_resp_mux_master_0_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    DEF_IDLE = 2'b00,
    DEF_ERR1 = 2'b01,
    DEF_ERR2 = 2'b10
  } def_state_e;

  // IDLE and BUSY need only a zero-wait OKAY; NONSEQ and SEQ are real accesses.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ml_ahb_resp_mux_master_0_if.sv
// ---------------------------------------------------------------------------
// ml_ahb_resp_mux_master_0_if
// Bus bundle between the master 0 decoder / slaves and the response stage.
//   slave  modport : the response stage (consumes selects and slave responses,
//                    produces hrdata/hready/hresp toward master 0)
//   master modport : the surrounding fabric (decoder, master, slaves)
// ---------------------------------------------------------------------------
interface ml_ahb_resp_mux_master_0_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2
);

  logic [NUM_SLAVES-1:0] hsel;
  logic                  hsel_default;
  logic [1:0]            htrans;
  logic [DATA_WIDTH-1:0] hrdata_s0;
  logic [DATA_WIDTH-1:0] hrdata_s1;
  logic                  hreadyout_s0;
  logic                  hreadyout_s1;
  logic [1:0]            hresp_s0;
  logic [1:0]            hresp_s1;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic [1:0]            hresp;

  modport slave (
    input  hsel, hsel_default, htrans,
    input  hrdata_s0, hrdata_s1, hreadyout_s0, hreadyout_s1, hresp_s0, hresp_s1,
    output hrdata, hready, hresp
  );

  modport master (
    output hsel, hsel_default, htrans,
    output hrdata_s0, hrdata_s1, hreadyout_s0, hreadyout_s1, hresp_s0, hresp_s1,
    input  hrdata, hready, hresp
  );

endinterface

// File: rtl/ml_ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ml_ahb_default_slave
// Default slave for unmapped accesses: answers every accepted active transfer
// with the two-cycle AHB ERROR response (hready low + ERROR, then hready high
// + ERROR).
//   hclk          : AHB clock
//   hreset        : synchronous active-high reset
//   accept        : an active default-slave transfer is accepted this cycle
//   hreadyout_def : default slave ready
//   hresp_def     : default slave response
// ---------------------------------------------------------------------------
module ml_ahb_default_slave
  import ml_ahb_resp_mux_master_0_pkg::*;
(
  input  logic   hclk,
  input  logic   hreset,
  input  logic   accept,
  output logic   hreadyout_def,
  output hresp_e hresp_def
);

  def_state_e state;
  def_state_e state_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge hclk) begin
    if (hreset) state <= DEF_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_next    = state;
    hreadyout_def = 1'b1;
    hresp_def     = HRESP_OKAY;
    unique case (state)
      DEF_IDLE: begin
        if (accept) state_next = DEF_ERR1;
      end
      DEF_ERR1: begin
        hreadyout_def = 1'b0;
        hresp_def     = HRESP_ERROR;
        state_next    = DEF_ERR2;
      end
      DEF_ERR2: begin
        hresp_def  = HRESP_ERROR;
        // A new active default transfer accepted here restarts the sequence.
        state_next = accept ? DEF_ERR1 : DEF_IDLE;
      end
      default: state_next = DEF_IDLE;
    endcase
  end

endmodule

// File: rtl/ml_ahb_resp_mux_master_0.sv
// ---------------------------------------------------------------------------
// ml_ahb_resp_mux_master_0
// Data-phase response stage behind the master 0 address decoder. Registers
// the address-phase select (dsel) and routes the selected slave's response
// back to master 0; unmapped accesses go to the internal default slave.
//   hclk   : AHB clock
//   hreset : synchronous active-high reset
//   bus    : slave modport of ml_ahb_resp_mux_master_0_if (selects, htrans,
//            per-slave hrdata/hreadyout/hresp in; hrdata/hready/hresp out).
//            bus.hready also feeds master 0 and every slave on this layer.
// The mux is written for the two slave ports present on the interface.
// ---------------------------------------------------------------------------
module ml_ahb_resp_mux_master_0
  import ml_ahb_resp_mux_master_0_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2
) (
  input logic                       hclk,
  input logic                       hreset,
  ml_ahb_resp_mux_master_0_if.slave bus
);

  localparam int DEF_BIT = NUM_SLAVES;

  logic [NUM_SLAVES:0]   dsel;
  logic [NUM_SLAVES:0]   dsel_load;
  logic                  any_hsel;
  logic                  accept_def;
  logic                  hreadyout_def;
  hresp_e                hresp_def;
  logic [DATA_WIDTH-1:0] hrdata_mux;
  logic                  hready_mux;
  logic [1:0]            hresp_mux;

  assign any_hsel = |bus.hsel;

  // Lowest-index select wins an overlap; the default slave only loads when
  // no real slave is addressed.
  always_comb begin
    dsel_load = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (bus.hsel[i]) dsel_load = (NUM_SLAVES + 1)'(1) << i;
    end
    if (!any_hsel && bus.hsel_default) dsel_load[DEF_BIT] = 1'b1;
  end

  // The address phase only completes when hready is high; otherwise the
  // current data phase is still in flight and the select must hold.
  always_ff @(posedge hclk) begin
    if (hreset)         dsel <= '0;
    else if (hready_mux) dsel <= dsel_load;
  end

  assign accept_def = hready_mux && bus.hsel_default && !any_hsel &&
                      is_active(bus.htrans);

  ml_ahb_default_slave u_default_slave (
    .hclk          (hclk),
    .hreset        (hreset),
    .accept        (accept_def),
    .hreadyout_def (hreadyout_def),
    .hresp_def     (hresp_def)
  );

  // No selection (idle bus / after reset) reads as a zero-wait OKAY.
  always_comb begin
    hrdata_mux = '0;
    hready_mux = 1'b1;
    hresp_mux  = HRESP_OKAY;
    if (dsel[DEF_BIT]) begin
      hready_mux = hreadyout_def;
      hresp_mux  = hresp_def;
    end else if (dsel[0]) begin
      hrdata_mux = bus.hrdata_s0;
      hready_mux = bus.hreadyout_s0;
      hresp_mux  = bus.hresp_s0;
    end else if (dsel[1]) begin
      hrdata_mux = bus.hrdata_s1;
      hready_mux = bus.hreadyout_s1;
      hresp_mux  = bus.hresp_s1;
    end
  end

  assign bus.hrdata = hrdata_mux;
  assign bus.hready = hready_mux;
  assign bus.hresp  = hresp_mux;

endmodule

// File: tb/tb_ml_ahb_resp_mux_master_0.sv
// ---------------------------------------------------------------------------
// tb_ml_ahb_resp_mux_master_0
// Directed scenarios followed by randomized traffic. A behavioural model
// tracks which endpoint owns the data phase and how many ERROR cycles remain,
// and predicts hready/hresp/hrdata every cycle.
// ---------------------------------------------------------------------------
module tb_ml_ahb_resp_mux_master_0;
  import ml_ahb_resp_mux_master_0_pkg::*;

  localparam int DW = 32;
  localparam int NS = 2;

  logic hclk = 1'b0;
  logic hreset;

  always #5 hclk = ~hclk;

  ml_ahb_resp_mux_master_0_if #(.DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

  ml_ahb_resp_mux_master_0 #(.DATA_WIDTH(DW), .NUM_SLAVES(NS)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus.slave)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model: owner of the current data phase (-1 none, 0..NS-1 slave, NS default)
  // and the number of ERROR response cycles still to be shown (2, 1 or 0).
  int m_owner;
  int m_err_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_outputs(output logic rdy, output logic [1:0] resp, output logic [31:0] data);
    rdy  = 1'b1;
    resp = HRESP_OKAY;
    data = '0;
    if (m_owner == NS) begin
      if (m_err_left == 2) rdy = 1'b0;
      if (m_err_left != 0) resp = HRESP_ERROR;
    end else if (m_owner == 0) begin
      rdy = bus.hreadyout_s0; resp = bus.hresp_s0; data = bus.hrdata_s0;
    end else if (m_owner == 1) begin
      rdy = bus.hreadyout_s1; resp = bus.hresp_s1; data = bus.hrdata_s1;
    end
  endtask

  // Literal expectation for directed steps; called right after the inputs
  // for the cycle have been driven.
  task automatic expect_out(input string tag, input logic rdy, input logic [1:0] resp,
                            input logic [31:0] data);
    #1;
    check({tag, "_hready"}, 32'(bus.hready), 32'(rdy));
    check({tag, "_hresp"},  32'(bus.hresp),  32'(resp));
    check({tag, "_hrdata"}, bus.hrdata,      data);
  endtask

  // Compare against the model, then advance one clock and update the model.
  task automatic tick(input string tag);
    logic        r;
    logic [1:0]  p;
    logic [31:0] d;
    int          n_owner;
    int          n_err;
    #1;
    model_outputs(r, p, d);
    check({tag, "_m_hready"}, 32'(bus.hready), 32'(r));
    check({tag, "_m_hresp"},  32'(bus.hresp),  32'(p));
    check({tag, "_m_hrdata"}, bus.hrdata,      d);
    if (hreset) begin
      n_owner = -1;
      n_err   = 0;
    end else begin
      n_owner = m_owner;
      n_err   = (m_err_left > 0) ? m_err_left - 1 : 0;
      if (r) begin
        n_owner = -1;
        for (int i = NS - 1; i >= 0; i--) if (bus.hsel[i]) n_owner = i;
        if (n_owner == -1 && bus.hsel_default) begin
          n_owner = NS;
          if (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ) n_err = 2;
        end
      end
    end
    @(posedge hclk);
    m_owner    = n_owner;
    m_err_left = n_err;
    @(negedge hclk);
  endtask

  task automatic drive(input logic [NS-1:0] sel, input logic def, input logic [1:0] trans);
    bus.hsel         = sel;
    bus.hsel_default = def;
    bus.htrans       = trans;
  endtask

  initial begin
    hreset           = 1'b1;
    drive('0, 1'b0, HTRANS_IDLE);
    bus.hrdata_s0    = 32'h1234_5678;
    bus.hrdata_s1    = 32'hCAFE_F00D;
    bus.hreadyout_s0 = 1'b0;
    bus.hreadyout_s1 = 1'b0;
    bus.hresp_s0     = HRESP_OKAY;
    bus.hresp_s1     = HRESP_OKAY;
    m_owner          = -1;
    m_err_left       = 0;

    // Reset for two cycles; slaves deliberately not ready to show dsel is empty.
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    expect_out("reset", 1'b1, HRESP_OKAY, 32'h0);
    tick("reset");

    // Slave 0 read with two wait states; a slave 1 select during the wait is ignored.
    bus.hreadyout_s0 = 1'b1;
    drive(2'b01, 1'b0, HTRANS_NONSEQ);
    tick("s0_addr");
    drive(2'b10, 1'b0, HTRANS_NONSEQ);
    bus.hreadyout_s0 = 1'b0;
    bus.hreadyout_s1 = 1'b1;
    expect_out("s0_wait1", 1'b0, HRESP_OKAY, 32'h1234_5678);
    tick("s0_wait1");
    expect_out("s0_wait2", 1'b0, HRESP_OKAY, 32'h1234_5678);
    tick("s0_wait2");
    drive('0, 1'b0, HTRANS_IDLE);
    bus.hreadyout_s0 = 1'b1;
    bus.hrdata_s0    = 32'hDEAD_BEEF;
    expect_out("s0_done", 1'b1, HRESP_OKAY, 32'hDEAD_BEEF);
    tick("s0_done");

    // Unmapped NONSEQ: two-cycle ERROR, then OKAY.
    drive('0, 1'b1, HTRANS_NONSEQ);
    tick("def_addr");
    drive('0, 1'b0, HTRANS_IDLE);
    expect_out("def_err1", 1'b0, HRESP_ERROR, 32'h0);
    tick("def_err1");
    expect_out("def_err2", 1'b1, HRESP_ERROR, 32'h0);
    tick("def_err2");
    expect_out("def_after", 1'b1, HRESP_OKAY, 32'h0);
    tick("def_after");

    // IDLE to the default slave: zero-wait OKAY, no error sequence.
    drive('0, 1'b1, HTRANS_IDLE);
    tick("def_idle_addr");
    drive('0, 1'b0, HTRANS_IDLE);
    expect_out("def_idle", 1'b1, HRESP_OKAY, 32'h0);
    tick("def_idle");

    // Back-to-back errors: a new NONSEQ accepted in the ERR2 cycle.
    drive('0, 1'b1, HTRANS_NONSEQ);
    tick("b2b_addr");
    drive('0, 1'b0, HTRANS_IDLE);
    expect_out("b2b_err1a", 1'b0, HRESP_ERROR, 32'h0);
    tick("b2b_err1a");
    drive('0, 1'b1, HTRANS_NONSEQ);
    expect_out("b2b_err2a", 1'b1, HRESP_ERROR, 32'h0);
    tick("b2b_err2a");
    drive('0, 1'b0, HTRANS_IDLE);
    expect_out("b2b_err1b", 1'b0, HRESP_ERROR, 32'h0);
    tick("b2b_err1b");
    expect_out("b2b_err2b", 1'b1, HRESP_ERROR, 32'h0);
    tick("b2b_err2b");
    expect_out("b2b_after", 1'b1, HRESP_OKAY, 32'h0);
    tick("b2b_after");

    // Reset during ERR1 aborts the sequence on the next edge.
    drive('0, 1'b1, HTRANS_NONSEQ);
    tick("rst_addr");
    drive('0, 1'b0, HTRANS_IDLE);
    hreset = 1'b1;
    expect_out("rst_err1", 1'b0, HRESP_ERROR, 32'h0);
    tick("rst_err1");
    hreset           = 1'b0;
    bus.hreadyout_s0 = 1'b0;
    bus.hreadyout_s1 = 1'b0;
    expect_out("rst_after", 1'b1, HRESP_OKAY, 32'h0);
    tick("rst_after");

    // Overlapping selects: slave 0 wins.
    drive(2'b11, 1'b0, HTRANS_NONSEQ);
    tick("ovl_addr");
    drive('0, 1'b0, HTRANS_IDLE);
    bus.hreadyout_s0 = 1'b1;
    bus.hreadyout_s1 = 1'b0;
    bus.hrdata_s0    = 32'hA5A5_0F0F;
    expect_out("ovl_data", 1'b1, HRESP_OKAY, 32'hA5A5_0F0F);
    tick("ovl_data");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      hreset           = ($urandom_range(0, 49) == 0);
      bus.hsel         = NS'($urandom_range(0, 3) == 0 ? $urandom : 0);
      bus.hsel_default = 1'($urandom);
      bus.htrans       = 2'($urandom);
      bus.hrdata_s0    = $urandom;
      bus.hrdata_s1    = $urandom;
      bus.hreadyout_s0 = ($urandom_range(0, 3) != 0);
      bus.hreadyout_s1 = ($urandom_range(0, 3) != 0);
      bus.hresp_s0     = 2'($urandom);
      bus.hresp_s1     = 2'($urandom);
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ml_ahb_resp_mux_master_0.md
Name: ml_ahb_resp_mux_master_0

Overview:
Data-phase response stage placed directly after the master 0 address decoder. It registers the address-phase slave select from the decoder and routes the selected slave's hrdata/hreadyout/hresp back to master 0. It contains the default slave, which answers unmapped accesses with the AHB two-cycle ERROR response. Its hready output also serves as the hready input to master 0 and to every slave on this layer.

Parameters:
DATA_WIDTH, 32, width of hrdata paths
NUM_SLAVES, 2, number of decoded slave endpoints (matches decoder hsel width)

Ports:
hclk  input  1  AHB clock, all state on rising edge
hreset  input  1  synchronous active-high reset
hsel  input  NUM_SLAVES  address-phase select from decoder
hsel_default  input  1  address-phase select of default slave, from decoder
htrans  input  2  master 0 transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
hrdata_s0  input  DATA_WIDTH  slave 0 read data
hrdata_s1  input  DATA_WIDTH  slave 1 read data
hreadyout_s0  input  1  slave 0 ready
hreadyout_s1  input  1  slave 1 ready
hresp_s0  input  2  slave 0 response
hresp_s1  input  2  slave 1 response
hrdata  output  DATA_WIDTH  read data to master 0
hready  output  1  combined ready to master 0 and all slaves
hresp  output  2  response to master 0 (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT)

Behaviour:
- Data-phase select register dsel[NUM_SLAVES:0]: bit NUM_SLAVES is the default slave. Loads only on a cycle where hready=1. While hready=0 it holds.
- Load value: one-hot of the lowest-index asserted hsel bit. If no hsel bit is asserted and hsel_default=1, the default bit loads. If nothing is asserted, dsel loads all-zero (no slave).
- Reset: dsel=0 and FSM=IDLE. Outputs then read hready=1, hresp=OKAY, hrdata=0. Reset asserted mid-transfer aborts any wait or ERROR sequence on the next edge.
- Output mux is purely combinational from dsel and the FSM:
  - slave i selected: hrdata=hrdata_si, hready=hreadyout_si, hresp=hresp_si.
  - no slave selected: hrdata=0, hready=1, hresp=OKAY.
  - default selected: hrdata=0; hready and hresp come from the FSM.
- Default-slave FSM (states IDLE, ERR1, ERR2):
  - IDLE: hready=1, hresp=OKAY. Moves to ERR1 when hready=1, hsel_default=1, no hsel bit is set and htrans[1]=1 (NONSEQ/SEQ). An IDLE/BUSY transfer to the default slave gets a zero-wait OKAY.
  - ERR1: hready=0, hresp=ERROR. Always moves to ERR2.
  - ERR2: hready=1, hresp=ERROR. Moves to ERR1 if another qualifying default transfer is accepted in this cycle, otherwise to IDLE.
- FSM outputs drive hready/hresp only when dsel selects the default slave. Otherwise the FSM stays in IDLE.
- Latency: zero added cycles for slave responses (combinational mux). Error response is exactly 2 cycles.
- The master must drive htrans=IDLE on the cycle it sees ERR1 (cancellation). This block tolerates a non-IDLE htrans there; the address is not accepted because hready=0.

Decomposition:
- Shared package/define file holds:
  - HTRANS codes: HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ
  - HRESP codes: HRESP_OKAY, HRESP_ERROR, HRESP_RETRY, HRESP_SPLIT
  - default-slave FSM state encoding
- One sub-module, ml_ahb_default_slave, holds the FSM and outputs hreadyout_def and hresp_def. The parent holds the dsel register and the mux.

Test Plan:
- Reset held 2 cycles, then released -> hready=1, hresp=00, hrdata=0x00000000.
- hsel=01, htrans=10; next cycle hreadyout_s0=0 for 2 cycles then 1, hrdata_s0=0xDEADBEEF -> hready low 2 cycles, then hrdata=0xDEADBEEF, hresp=00. A hsel=10 presented during the wait does not change dsel.
- hsel_default=1, htrans=10 -> cycle+1: hready=0, hresp=01; cycle+2: hready=1, hresp=01; cycle+3: hresp=00.
- hsel_default=1, htrans=00 -> next cycle hready=1, hresp=00, FSM stays IDLE.
- Back-to-back default NONSEQ accepted in ERR2 cycle -> ERR1, ERR2, ERR1, ERR2 sequence with no OKAY between.
- hreset asserted during ERR1 -> next edge: hready=1, hresp=00, dsel=0.
- Overlap hsel=11 with hreadyout_s0=1, hreadyout_s1=0 -> slave 0 wins: hready=1, hrdata=hrdata_s0.
